// File: rtl/pcie_rx_mem_decoder.sv
// -----------------------------------------------------------------------------
// pcie_rx_mem_decoder
//
// Receive-side TLP engine for the 64-bit TRN RX interface of the PCIe endpoint.
// Host 1-DW memory writes become a one-cycle register-bus write strobe; host
// 1-DW memory reads become a level-held completion request for the TX
// completion engine. Anything else (other types, length != 1, BAR miss) is
// drained and counted.
//
// Ports:
//   trn_clk, trn_reset        core clock, synchronous active-high reset
//   trn_rd, trn_rrem_n        RX data beat (DW0 in [63:32], DW1 in [31:0])
//   trn_rsof_n, trn_reof_n    start / end of TLP (active low)
//   trn_rsrc_rdy_n            source ready (active low)
//   trn_rsrc_dsc_n            source discontinue (active low)
//   trn_rbar_hit_n            BAR hit, valid on the SOF beat (active low)
//   trn_rdst_rdy_n            destination ready (active low)
//   wr_en_o .. wr_be_o        register write strobe, DW address, data, BEs
//   req_compl_o, compl_done_i completion request / acknowledge handshake
//   req_* (tc..addr)          completion header fields, stable while requested
//   unsup_cnt_o               saturating count of discarded TLPs
// -----------------------------------------------------------------------------
module pcie_rx_mem_decoder #(
   parameter logic [6:0]  BAR_MASK = 7'b0000001,
   parameter int unsigned ADDR_W   = 11
) (
   input  logic              trn_clk,
   input  logic              trn_reset,
   input  logic [63:0]       trn_rd,
   input  logic [7:0]        trn_rrem_n,
   input  logic              trn_rsof_n,
   input  logic              trn_reof_n,
   input  logic              trn_rsrc_rdy_n,
   input  logic              trn_rsrc_dsc_n,
   input  logic [6:0]        trn_rbar_hit_n,
   output logic              trn_rdst_rdy_n,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic [3:0]        wr_be_o,
   output logic              req_compl_o,
   input  logic              compl_done_i,
   output logic [2:0]        req_tc_o,
   output logic              req_td_o,
   output logic              req_ep_o,
   output logic [1:0]        req_attr_o,
   output logic [9:0]        req_len_o,
   output logic [15:0]       req_rid_o,
   output logic [7:0]        req_tag_o,
   output logic [7:0]        req_be_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [15:0]       unsup_cnt_o
);

   localparam logic [6:0] TYPE_MRD32 = 7'h00;
   localparam logic [6:0] TYPE_MRD64 = 7'h20;
   localparam logic [6:0] TYPE_MWR32 = 7'h40;
   localparam logic [6:0] TYPE_MWR64 = 7'h60;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_WAIT_CPL,
      S_WR32,
      S_WR64_ADDR,
      S_WR64_DATA,
      S_DRAIN
   } state_t;

   function automatic logic [31:0] byteswap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   state_t state_q, state_d;

   // Beat qualifiers.
   logic beat_ok, sof, eof;
   assign beat_ok = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
   assign sof     = ~trn_rsof_n;
   assign eof     = ~trn_reof_n;

   // Header decode, meaningful only on an SOF beat.
   logic [6:0] hdr_type;
   logic       hdr_known, hdr_len_ok, hdr_bar_ok, hdr_ok;
   assign hdr_type   = trn_rd[62:56];
   assign hdr_known  = hdr_type inside {TYPE_MRD32, TYPE_MRD64, TYPE_MWR32, TYPE_MWR64};
   assign hdr_len_ok = (trn_rd[41:32] == 10'd1);
   assign hdr_bar_ok = |(~trn_rbar_hit_n & BAR_MASK);
   assign hdr_ok     = hdr_known & hdr_len_ok & hdr_bar_ok;

   // Only address bits [ADDR_W+1:2] and the beat framing matter here; rrem_n
   // is implied by the state machine position.
   logic unused_ok;
   assign unused_ok = &{1'b0, trn_rrem_n, trn_rd};

   // Latched header fields.
   logic [2:0]        hdr_tc;
   logic              hdr_td, hdr_ep, hdr_4dw;
   logic [1:0]        hdr_attr;
   logic [9:0]        hdr_len;
   logic [15:0]       hdr_rid;
   logic [7:0]        hdr_tag, hdr_be;
   logic [ADDR_W-1:0] wr64_addr;

   // FSM decisions for the current cycle.
   logic take_hdr, cnt_inc, wr_fire, rd_fire, addr_take;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge trn_clk) begin
      if (trn_reset) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // Next-state and control decode
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      take_hdr  = 1'b0;
      cnt_inc   = 1'b0;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;
      addr_take = 1'b0;

      if (state_q == S_WAIT_CPL) begin
         // No beats are accepted here; discontinue does not apply.
         if (compl_done_i) state_d = S_IDLE;
      end else if (!trn_rsrc_dsc_n) begin
         state_d = S_IDLE;
      end else if (beat_ok) begin
         // SOF mid-TLP restarts decode on that beat; inside DRAIN every beat
         // belongs to the TLP being discarded.
         if (sof && state_q != S_DRAIN) begin
            take_hdr = 1'b1;
            if (!hdr_ok) begin
               cnt_inc = 1'b1;
               state_d = eof ? S_IDLE : S_DRAIN;
            end else begin
               unique case (hdr_type)
                  TYPE_MRD32, TYPE_MRD64: state_d = S_RD_ADDR;
                  TYPE_MWR32:             state_d = S_WR32;
                  default:                state_d = S_WR64_ADDR;
               endcase
            end
         end else begin
            case (state_q)
               S_RD_ADDR: begin
                  rd_fire = 1'b1;
                  state_d = S_WAIT_CPL;
               end
               S_WR32: begin
                  wr_fire = 1'b1;
                  state_d = S_IDLE;
               end
               S_WR64_ADDR: begin
                  addr_take = 1'b1;
                  state_d   = S_WR64_DATA;
               end
               S_WR64_DATA: begin
                  wr_fire = 1'b1;
                  state_d = S_IDLE;
               end
               S_DRAIN: begin
                  if (eof) state_d = S_IDLE;
               end
               default: ;  // stray non-SOF beat in IDLE is ignored
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // Datapath and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge trn_clk) begin
      if (trn_reset) begin
         trn_rdst_rdy_n <= 1'b1;
         wr_en_o        <= 1'b0;
         wr_addr_o      <= '0;
         wr_data_o      <= '0;
         wr_be_o        <= '0;
         req_compl_o    <= 1'b0;
         req_tc_o       <= '0;
         req_td_o       <= 1'b0;
         req_ep_o       <= 1'b0;
         req_attr_o     <= '0;
         req_len_o      <= '0;
         req_rid_o      <= '0;
         req_tag_o      <= '0;
         req_be_o       <= '0;
         req_addr_o     <= '0;
         unsup_cnt_o    <= '0;
         hdr_tc         <= '0;
         hdr_td         <= 1'b0;
         hdr_ep         <= 1'b0;
         hdr_attr       <= '0;
         hdr_len        <= '0;
         hdr_rid        <= '0;
         hdr_tag        <= '0;
         hdr_be         <= '0;
         hdr_4dw        <= 1'b0;
         wr64_addr      <= '0;
      end else begin
         // Back-pressure exactly while a completion is outstanding.
         trn_rdst_rdy_n <= (state_d == S_WAIT_CPL);
         wr_en_o        <= wr_fire;

         if (take_hdr) begin
            hdr_tc   <= trn_rd[54:52];
            hdr_td   <= trn_rd[47];
            hdr_ep   <= trn_rd[46];
            hdr_attr <= trn_rd[45:44];
            hdr_len  <= trn_rd[41:32];
            hdr_4dw  <= hdr_type[5];
            hdr_rid  <= trn_rd[31:16];
            hdr_tag  <= trn_rd[15:8];
            hdr_be   <= trn_rd[7:0];
         end

         if (cnt_inc && unsup_cnt_o != 16'hFFFF)
            unsup_cnt_o <= unsup_cnt_o + 16'd1;

         if (addr_take)
            wr64_addr <= trn_rd[ADDR_W+1:2];

         if (wr_fire) begin
            wr_be_o <= hdr_be[3:0];
            if (state_q == S_WR32) begin
               wr_addr_o <= trn_rd[ADDR_W+33:34];
               wr_data_o <= byteswap(trn_rd[31:0]);
            end else begin
               wr_addr_o <= wr64_addr;
               wr_data_o <= byteswap(trn_rd[63:32]);
            end
         end

         if (rd_fire) begin
            req_compl_o <= 1'b1;
            req_tc_o    <= hdr_tc;
            req_td_o    <= hdr_td;
            req_ep_o    <= hdr_ep;
            req_attr_o  <= hdr_attr;
            req_len_o   <= hdr_len;
            req_rid_o   <= hdr_rid;
            req_tag_o   <= hdr_tag;
            req_be_o    <= hdr_be;
            req_addr_o  <= hdr_4dw ? trn_rd[ADDR_W+1:2] : trn_rd[ADDR_W+33:34];
         end else if (state_q == S_WAIT_CPL && compl_done_i) begin
            req_compl_o <= 1'b0;
         end
      end
   end

endmodule
